// File: rtl/im_program_loader_pkg.sv
// -----------------------------------------------------------------------------
// im_program_loader_pkg
// Shared definitions for the instruction-memory program loader:
//   - state_t    : loader FSM state encoding (IDLE/LOAD/WRITE/DONE)
//   - IM_ADDR_W  : IM byte-address width (IM spans 0x000..0xFFF)
//   - WORD_BYTES : bytes packed into one IM word
//   - CNT_W_DEF  : default width of the word counter (max load 1024 words)
// -----------------------------------------------------------------------------
package im_program_loader_pkg;

    localparam int IM_ADDR_W  = 12;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W_DEF  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/im_program_loader_if.sv
// -----------------------------------------------------------------------------
// im_program_loader_if
// Groups the byte-stream handshake and the IM write bus of the loader.
//   s_valid/s_data : byte stream into the loader
//   s_ready        : loader can accept a byte
//   IM_cs/IM_wr/IM_rd/IM_addr/IM_din : instruction-memory port
// Modports:
//   master : the loader (drives s_ready and the IM bus, consumes the stream)
//   slave  : the environment (byte source and the IM itself)
// -----------------------------------------------------------------------------
interface im_program_loader_if;

    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        IM_cs;
    logic        IM_wr;
    logic        IM_rd;
    logic [31:0] IM_addr;
    logic [31:0] IM_din;

    modport master (
        input  s_valid, s_data,
        output s_ready, IM_cs, IM_wr, IM_rd, IM_addr, IM_din
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, IM_cs, IM_wr, IM_rd, IM_addr, IM_din
    );

endinterface

// File: rtl/im_program_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// im_program_loader_byte_packer
// Packs bytes big-endian into a 32-bit word: the first byte ends in [31:24],
// the fourth in [7:0].
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   i_clr          : synchronous clear of counter and shift register
//   i_shift        : shift i_byte in (one accepted byte)
//   i_byte         : incoming byte
//   o_word         : current shift-register contents
//   o_word_full    : three bytes held; the next shifted byte completes a word
// -----------------------------------------------------------------------------
module im_program_loader_byte_packer
    import im_program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_shift) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {r_word[23:0], i_byte};
        end
    end

    assign o_word      = r_word;
    assign o_word_full = (r_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/im_program_loader.sv
// -----------------------------------------------------------------------------
// im_program_loader
// Fills the instruction memory from a byte stream. Bytes are packed into
// big-endian words and written at consecutive word addresses starting at a
// word-aligned base. The CPU is held while loading; done pulses on completion.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   start              : begin a load (sampled only in IDLE)
//   abort              : cancel a load in progress (LOAD/WRITE only)
//   base_addr          : start byte address, bits [1:0] ignored
//   word_count         : number of words to load, captured on start
//   bus (master)       : byte-stream handshake + IM write port
//   busy / cpu_hold    : load in progress
//   done               : one-cycle pulse on successful completion
//   err                : sticky; address wrap or abort, cleared by next start
// -----------------------------------------------------------------------------
module im_program_loader
    import im_program_loader_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    im_program_loader_if.master bus,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_addr_hold;
    logic [CNT_W-1:0]   r_words_left;
    logic [31:0]        r_din_hold;
    logic               r_err;

    logic               w_start_ok;
    logic               w_accept;
    logic               w_word_full;
    logic [31:0]        w_word;
    logic               w_last;
    logic               w_wrap;
    logic               w_abort_ok;
    logic               w_pack_clr;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_accept   = (r_state == LOAD) && bus.s_valid;
    assign w_last     = (r_words_left == CNT_W'(1));
    assign w_abort_ok = abort && ((r_state == LOAD) || (r_state == WRITE));
    // Wrap: writing the top word while more words remain.
    assign w_wrap     = (r_state == WRITE) && (&r_addr[ADDR_W-1:2])
                        && (r_words_left > CNT_W'(1));
    // A new load and each completed word start the packer from empty, so
    // bytes left over from an aborted load never leak into the next word.
    assign w_pack_clr = w_start_ok || (r_state == WRITE);

    im_program_loader_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (w_pack_clr),
        .i_shift     (w_accept),
        .i_byte      (bus.s_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (word_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_accept && w_word_full) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = LOAD;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs: decoded from state and registers only. Outside WRITE the IM
    // address/data show the last written word via the hold registers.
    always_comb begin
        bus.s_ready = (r_state == LOAD);
        bus.IM_cs   = (r_state == WRITE);
        bus.IM_wr   = (r_state == WRITE);
        bus.IM_rd   = 1'b0;
        bus.IM_addr = {{(32-ADDR_W){1'b0}},
                       (r_state == WRITE) ? r_addr : r_addr_hold};
        bus.IM_din  = (r_state == WRITE) ? w_word : r_din_hold;
        busy        = (r_state == LOAD) || (r_state == WRITE);
        cpu_hold    = (r_state == LOAD) || (r_state == WRITE);
        done        = (r_state == DONE);
        err         = r_err;
    end

    // Address / word counter / hold registers / error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr       <= '0;
            r_addr_hold  <= '0;
            r_words_left <= '0;
            r_din_hold   <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_addr       <= base_addr & ~ADDR_W'(3);
                r_words_left <= word_count;
            end else if (r_state == WRITE) begin
                // Natural modulo-2^ADDR_W wrap of the byte address.
                r_addr       <= r_addr + ADDR_W'(WORD_BYTES);
                r_words_left <= r_words_left - CNT_W'(1);
                r_addr_hold  <= r_addr;
                r_din_hold   <= w_word;
            end

            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_abort_ok || w_wrap) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/im_program_loader.md
Name: im_program_loader

Overview:
- Writer side of the instruction memory. The fetch path only ever reads IM; this block fills it.
- Accepts a byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit words.
- Writes each word into IM using IM_cs/IM_wr at consecutive word addresses.
- Holds the CPU (cpu_hold) while loading and pulses done when the program image is complete.

Parameters:
ADDR_W, 12, IM byte-address width; IM covers byte addresses 0x000..0xFFF.
CNT_W, 11, width of word_count; the maximum load is 1024 words.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a load; sampled only in IDLE
abort  in  1  synchronous cancel of a load in progress
base_addr  in  ADDR_W  start byte address; bits [1:0] ignored (forced word-aligned)
word_count  in  CNT_W  number of words to load; captured on start
s_valid  in  1  byte-stream valid
s_data  in  8  byte-stream data
s_ready  out  1  loader can accept a byte
IM_cs  out  1  IM chip select
IM_wr  out  1  IM write strobe
IM_rd  out  1  IM read strobe; constant 0
IM_addr  out  32  {20'b0, byte address}
IM_din  out  32  packed word
busy  out  1  load in progress
cpu_hold  out  1  equals busy; gates PC_ld/IR_ld upstream
done  out  1  one-cycle pulse at successful completion
err  out  1  sticky flag: address wrap or abort; cleared by the next accepted start

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - All outputs are 0. Internal address, word counter, byte counter and shift register are 0.
- States are IDLE, LOAD, WRITE, DONE.
- IDLE:
  - s_ready=0, busy=0.
  - On start=1, capture base_addr with [1:0] cleared, capture word_count, clear err.
  - word_count==0: go to DONE (no write occurs). Otherwise go to LOAD.
- LOAD:
  - s_ready=1, busy=1.
  - A byte is accepted when s_valid and s_ready are both 1 on a rising edge.
  - Bytes shift in big-endian: 1st byte lands in [31:24], 4th byte in [7:0].
  - Byte counter (2 bits) increments per accepted byte. Acceptance of the 4th byte moves to WRITE.
  - Acceptance of the 4th byte causes the next state to drive s_ready=0, so a 5th byte cannot be accepted early.
- WRITE (exactly one cycle):
  - IM_cs=1, IM_wr=1, IM_addr={20'b0,addr}, IM_din=word.
  - Next edge: addr advances by 4 modulo 2^ADDR_W, words_left decrements, byte counter clears.
  - If addr was 0xFFC and words_left>1, the address wraps to 0x000 and err is set. The load continues.
  - If words_left becomes 0, go to DONE; otherwise go to LOAD.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Latency and throughput:
  - The IM write occurs in the cycle after the 4th byte is accepted.
  - Minimum 5 cycles per word (4 byte cycles plus 1 write cycle).
- abort:
  - In LOAD: go to IDLE. The partial word is discarded and never written. err=1, done is not pulsed.
  - In WRITE: abort has priority over the write. IM_cs and IM_wr are still asserted that cycle, because outputs are registered from state, so the word completes; the FSM then goes to IDLE with err=1.
- start while busy is ignored.
- abort in IDLE or DONE is ignored.
- Outputs IM_cs, IM_wr, IM_addr, IM_din and done are driven registered or decoded from registered state only. s_valid and s_data have no combinational path to them.
- IM_addr and IM_din hold their last values outside WRITE. IM_cs and IM_wr are 0 outside WRITE.
- Reset asserted mid-load returns immediately to the reset values. A partially written image is not recovered.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE=2'b00, LOAD=2'b01, WRITE=2'b10, DONE=2'b11.
  - IM_ADDR_W=12.
  - WORD_BYTES=4.
- One natural sub-module, byte_packer: a 2-bit counter plus 32-bit shift register with clear and a "word_full" output.
- The FSM, address counter and word counter stay in the top level.

Test Plan:
1. Reset low then high; start with base 0x010, count 2; bytes 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0 back-to-back -> writes 0x12345678 @0x010, then 0x9ABCDEF0 @0x014; done pulses once; err=0.
2. s_valid toggled every other cycle during a 1-word load -> write happens exactly once, the cycle after the 4th accepted byte; s_ready=0 in the WRITE cycle.
3. start with count 0 -> done pulses one cycle later; no IM_cs.
4. base 0xFFC, count 2 -> writes @0xFFC then @0x000; err=1 after the second write; done pulses.
5. abort after 2 bytes of word 2 of 3 -> only word 1 written; busy falls, err=1, no done. A fresh start clears err.
6. reset driven low during LOAD after 3 bytes -> all outputs 0 immediately and no write. A subsequent load of 1 word writes the correct word with no stale bytes.
